// File: rtl/packet_assembler.sv
// HDMI data-island packet assembler: appends BCH parity to the header and
// subpackets and serialises one 32-pixel packet as 9 bits per pixel.
module packet_assembler (
    input  logic             clk_pixel,
    input  logic             reset,
    input  logic             data_island_period,
    input  logic [23:0]      header,
    input  logic [3:0][55:0] sub,
    output logic [4:0]       counter,
    output logic             packet_enable,
    output logic [8:0]       packet_data
);

    logic [7:0]      ecc_h;
    logic [3:0][7:0] ecc_s;

    logic            hdr_bit;
    logic [3:0]      even_bit;
    logic [3:0]      odd_bit;
    logic [7:0]      ecc_h_next;
    logic [3:0][7:0] ecc_s_next;

    function automatic logic [7:0] ecc_step(input logic [7:0] e, input logic b);
        return (e >> 1) ^ ((e[0] ^ b) ? 8'h83 : 8'h00);
    endfunction

    // Parity phase index: counter-24 and counter-28 reduce to low bits.
    always_comb begin
        hdr_bit = (counter < 5'd24) ? header[counter] : ecc_h[counter[2:0]];
        even_bit = '0;
        odd_bit = '0;
        for (int k = 0; k < 4; k++) begin
            if (counter < 5'd28) begin
                even_bit[k] = sub[k][{counter, 1'b0}];
                odd_bit[k]  = sub[k][{counter, 1'b1}];
            end else begin
                even_bit[k] = ecc_s[k][{counter[1:0], 1'b0}];
                odd_bit[k]  = ecc_s[k][{counter[1:0], 1'b1}];
            end
        end
    end

    always_comb begin
        ecc_h_next = ecc_step(ecc_h, hdr_bit);
        ecc_s_next = '0;
        for (int k = 0; k < 4; k++)
            ecc_s_next[k] = ecc_step(ecc_step(ecc_s[k], even_bit[k]), odd_bit[k]);
    end

    always_ff @(posedge clk_pixel) begin
        if (reset || !data_island_period) begin
            counter <= '0;
            ecc_h   <= '0;
            ecc_s   <= '0;
        end else begin
            counter <= counter + 5'd1;
            if (counter == 5'd31) begin
                ecc_h <= '0;
                ecc_s <= '0;
            end else begin
                if (counter < 5'd24)
                    ecc_h <= ecc_h_next;
                if (counter < 5'd28)
                    ecc_s <= ecc_s_next;
            end
        end
    end

    assign packet_enable = data_island_period && (counter == 5'd31);
    assign packet_data   = {odd_bit, even_bit, hdr_bit};

endmodule

// File: doc/packet_assembler.md
Name: packet_assembler

Overview:
- Consumes the 24-bit header and four 56-bit subpackets selected by the packet picker.
- Appends BCH(32,24) ECC to the header and BCH(64,56) ECC to each subpacket.
- Serialises one 32-pixel HDMI data-island packet as 9 bits per pixel for the TERC4 channel encoders.
- Owns the packet pixel counter that the picker uses, and generates the picker's packet_enable strobe.

Parameters:
- None. Packet length is fixed at 32 pixels.
- ECC polynomial is fixed at G(x)=1+x^6+x^7+x^8.

Ports:
- clk_pixel  in  1  pixel clock
- reset  in  1  reset, synchronous, active-high; clock clk_pixel
- data_island_period  in  1  high for every pixel of a data island (whole multiples of 32 pixels)
- header  in  24  packet header HB2..HB0; must be stable for the whole packet
- sub  in  4x56  subpackets 0..3; must be stable for the whole packet
- counter  out  5  pixel index within the current packet, 0..31 (feeds picker packet_pixel_counter)
- packet_enable  out  1  high when data_island_period && counter==31; picker loads the next packet on this cycle
- packet_data  out  9  bit0 = header stream bit (goes to channel 0 bit 2); bits4:1 = sub[3:0] even bit (channel 1); bits8:5 = sub[3:0] odd bit (channel 2)

Behaviour:
- Registers:
  - counter[4:0]
  - ecc_h[7:0]
  - ecc_s[3:0][7:0]
- Reset (sync, highest priority): counter=0, ecc_h=0, ecc_s=0.
  - Outputs after reset: counter=0, packet_enable=0, packet_data=combinational value for counter 0 using the current inputs (0 if inputs are 0).
- Counter:
  - When data_island_period=1: counter <= counter+1, wrapping 31->0.
  - When data_island_period=0: counter <= 0.
  - A drop of data_island_period mid-packet aborts the packet: counter and all ECC registers return to 0 the next cycle.
- Serial ECC step: f(e,b) = (e>>1) ^ ((e[0]^b) ? 8'h83 : 8'h00).
- Header stream, combinational on counter:
  - counter<24: bit = header[counter].
  - counter>=24: bit = ecc_h[counter-24]. Parity is transmitted LSB first.
  - On each data-island clock with counter<24: ecc_h <= f(ecc_h, header[counter]).
- Subpacket k stream:
  - counter<28: even = sub[k][2*counter], odd = sub[k][2*counter+1].
  - counter>=28: even = ecc_s[k][2*(counter-28)], odd = ecc_s[k][2*(counter-28)+1].
  - On each data-island clock with counter<28: ecc_s[k] <= f(f(ecc_s[k], even), odd), with the even bit applied first.
- Clearing between packets:
  - When counter==31 (island high), all ECC registers <= 0 so the next packet starts clean.
  - Back-to-back packets need no idle cycle.
- Outside a data island:
  - packet_data still reflects counter=0 combinationally; downstream ignores it.
  - ECC registers hold 0.
- Latency:
  - packet_data is combinational from counter, the ECC registers and the inputs; zero cycles from input to output.
  - ECC parity is complete at the boundary counter 23->24 (header) and 27->28 (subpackets).
- Input stability:
  - The picker updates header/sub on the clock where packet_enable=1, so the new values appear at counter=0.
  - A change to header or sub mid-packet corrupts that packet's ECC. This is not detected; it is a bench assertion.
- Simultaneous reset and data_island_period: reset wins.

Test Plan:
- Null packet: header=0, sub=0, one 32-pixel island -> packet_data=9'h000 on all 32 pixels; counter steps 0..31; packet_enable high only at counter 31.
- Header 24'h000001, sub=0 -> bit0 stream is 1 at counter 0, 0 at counters 1..23, then ecc 8'h4A LSB first: counters 24..31 = 0,1,0,1,0,0,1,0.
- Subpacket check: sub[2]=56'h1, other subpackets 0 -> packet_data[3] (sub 2 even bit) is 1 at counter 0; ECC bits at counters 28..31 match the bench model of double-stepped f; other subpacket lanes stay 0.
- Back-to-back: two-packet island, first packet header 24'h000001, second header=0 -> second packet's parity bits are all 0, proving ECC cleared at counter 31.
- Abort: data_island_period drops at counter 10 -> next cycle counter=0 and ECC registers 0; a fresh island then yields the correct ECC for its packet.
- Reset mid-packet at counter 17 -> counter=0 and packet_enable=0 the next cycle; the following packet's ECC is correct.
